regfile_write_scheduler: RTL

- Shares the single register-file write port between two writeback requesters: req0 (ALU/execute) and req1 (load/memory).
- Uses a 2-way round-robin grant and a registered write stage that drives the register file's wr_ena, wr_addr and wr_data.
- Keeps a 32-entry pending-write scoreboard so issue logic can stall on read-after-write hazards against register-file reads.

---
 rtl/regfile_write_scheduler_pkg.sv | 15 +
 rtl/decoder.sv | 17 +
 rtl/rr_arb2.sv | 41 ++++
 rtl/regfile_write_scheduler.sv | 112 +++++++++++
 4 files changed

// File: rtl/regfile_write_scheduler_pkg.sv
// Shared constants for the register-file write scheduler: address width,
// register count, the hardwired zero register and requester grant encodings.
package regfile_write_scheduler_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    localparam int unsigned REQ_ALU = 0;
    localparam int unsigned REQ_MEM = 1;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/decoder.sv
// Binary to one-hot decoder with enable; all outputs low when disabled.
module decoder #(
    parameter int unsigned W = 5
) (
    input  logic              enable,
    input  logic [W-1:0]      addr,
    output logic [2**W-1:0]   onehot
);

    always_comb begin
        onehot = '0;
        if (enable) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. On contention the requester that did not win
// last is granted; the history bit moves only when a grant is consumed.
module rr_arb2
    import regfile_write_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       xfer,
    output logic [1:0] grant
);

    logic last_grant_q, last_grant_d;

    always_comb begin
        grant = 2'b00;
        unique case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (xfer) begin
            last_grant_d = grant[REQ_MEM];
        end
    end

    // Reset to requester 1 so requester 0 wins the first contended cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Arbitrates the single register-file write port between ALU and load
// writeback, and tracks outstanding writes for read-after-write stalls.
module regfile_write_scheduler
    import regfile_write_scheduler_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [4:0]          req0_addr,
    input  logic [N-1:0]        req0_data,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [4:0]          req1_addr,
    input  logic [N-1:0]        req1_data,
    input  logic                rsv_valid,
    input  logic [4:0]          rsv_addr,
    input  logic [4:0]          rd_addr1,
    input  logic [4:0]          rd_addr2,
    output logic                rd_busy1,
    output logic                rd_busy2,
    output logic                wr_ena,
    output logic [4:0]          wr_addr,
    output logic [N-1:0]        wr_data,
    output logic [NUM_REGS-1:0] pending
);

    logic [1:0]          grant;
    logic [1:0]          ready;
    logic                xfer;
    reg_addr_t           sel_addr;
    logic [N-1:0]        sel_data;

    logic                wr_ena_q;
    reg_addr_t           wr_addr_q;
    logic [N-1:0]        wr_data_q;

    logic [NUM_REGS-1:0] set_mask, clr_mask;
    logic [NUM_REGS-1:0] pending_q, pending_d;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .valid ({req1_valid, req0_valid}),
        .xfer  (xfer),
        .grant (grant)
    );

    // No grants are visible while reset is held.
    assign ready      = grant & {2{rst}};
    assign xfer       = |ready;
    assign req0_ready = ready[REQ_ALU];
    assign req1_ready = ready[REQ_MEM];

    assign sel_addr = ready[REQ_MEM] ? req1_addr : req0_addr;
    assign sel_data = ready[REQ_MEM] ? req1_data : req0_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ena_q  <= 1'b0;
            wr_addr_q <= ZERO_REG;
            wr_data_q <= '0;
        end else begin
            wr_ena_q <= xfer && (sel_addr != ZERO_REG);
            if (xfer) begin
                wr_addr_q <= sel_addr;
                wr_data_q <= sel_data;
            end
        end
    end

    decoder #(
        .W (REG_ADDR_W)
    ) u_set_dec (
        .enable (rsv_valid),
        .addr   (rsv_addr),
        .onehot (set_mask)
    );

    decoder #(
        .W (REG_ADDR_W)
    ) u_clr_dec (
        .enable (wr_ena_q),
        .addr   (wr_addr_q),
        .onehot (clr_mask)
    );

    // Set is applied after clear: a same-edge reservation belongs to a newer write.
    always_comb begin
        pending_d    = (pending_q & ~clr_mask) | set_mask;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign rd_busy1 = pending_q[rd_addr1];
    assign rd_busy2 = pending_q[rd_addr2];

    assign wr_ena  = wr_ena_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign pending = pending_q;

endmodule
